// File: rtl/door_fsm_timed.sv
// Automatic-door controller with a tick prescaler, timed travel and hold phases, obstacle-retry
// limiting and a latched FAULT state. Define LIMIT_SW_EN to end travel on synchronised limit switches.
module door_fsm_timed #(
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter int unsigned TRAVEL_TICKS = 3,
  parameter int unsigned HOLD_TICKS   = 5,
  parameter int unsigned MAX_RETRIES  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sense,
  input  logic       obs,
  input  logic       ack,
`ifdef LIMIT_SW_EN
  input  logic       lim_open,
  input  logic       lim_closed,
`endif
  output logic [1:0] motor,
  output logic       alarm,
  output logic       rev_pulse,
  output logic [2:0] state_o,
  output logic       tick_led
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TW = $clog2(TRAVEL_TICKS + 1);
  localparam int unsigned HW = $clog2(HOLD_TICKS + 1);
  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

  localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_TICKS - 1);
  localparam logic [RW-1:0] RETRY_LAST  = RW'(MAX_RETRIES - 1);

  localparam logic [1:0] M_STOP  = 2'b00;
  localparam logic [1:0] M_OPEN  = 2'b01;
  localparam logic [1:0] M_CLOSE = 2'b10;

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    OPENING = 3'd1,
    OPEN    = 3'd2,
    CLOSING = 3'd3,
    FAULT   = 3'd4
  } state_t;

  state_t          state;
  logic [PW-1:0]   presc;
  logic            tick;
  logic [TW-1:0]   travel_cnt;
  logic [HW-1:0]   hold_cnt;
  logic [RW-1:0]   retry_cnt;
  logic            travel_last;

  logic [1:0]      sense_sync;
  logic [1:0]      obs_sync;
  logic            sense_s;
  logic            obs_s;

`ifdef LIMIT_SW_EN
  logic [1:0]      lim_open_sync;
  logic [1:0]      lim_closed_sync;
  logic            lim_open_s;
  logic            lim_closed_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      lim_open_sync   <= '0;
      lim_closed_sync <= '0;
    end else begin
      lim_open_sync   <= {lim_open_sync[0], lim_open};
      lim_closed_sync <= {lim_closed_sync[0], lim_closed};
    end
  end

  assign lim_open_s   = lim_open_sync[1];
  assign lim_closed_s = lim_closed_sync[1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sense_sync <= '0;
      obs_sync   <= '0;
    end else begin
      sense_sync <= {sense_sync[0], sense};
      obs_sync   <= {obs_sync[0], obs};
    end
  end

  assign sense_s = sense_sync[1];
  assign obs_s   = obs_sync[1];

  // Prescaler yields a single-cycle enable; nothing else is clocked off it.
  assign tick = (presc == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      tick_led <= 1'b0;
    end else if (tick) begin
      presc    <= '0;
      tick_led <= ~tick_led;
    end else begin
      presc    <= presc + 1'b1;
    end
  end

  assign travel_last = (travel_cnt == TRAVEL_LAST);
  assign state_o     = state;

  // Outputs are assigned alongside every state change so they stay registered with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLOSED;
      travel_cnt <= '0;
      hold_cnt   <= '0;
      retry_cnt  <= '0;
      motor      <= M_STOP;
      alarm      <= 1'b0;
      rev_pulse  <= 1'b0;
    end else begin
      rev_pulse <= 1'b0;
      case (state)
        CLOSED: begin
          if (sense_s) begin
            state      <= OPENING;
            motor      <= M_OPEN;
            travel_cnt <= '0;
            retry_cnt  <= '0;
          end
        end

        OPENING: begin
`ifdef LIMIT_SW_EN
          if (lim_open_s) begin
            state    <= OPEN;
            motor    <= M_STOP;
            hold_cnt <= '0;
          end else if (tick) begin
            if (travel_last) begin
              state <= FAULT;
              motor <= M_STOP;
              alarm <= 1'b1;
            end else begin
              travel_cnt <= travel_cnt + 1'b1;
            end
          end
`else
          if (tick) begin
            if (travel_last) begin
              state    <= OPEN;
              motor    <= M_STOP;
              hold_cnt <= '0;
            end else begin
              travel_cnt <= travel_cnt + 1'b1;
            end
          end
`endif
        end

        OPEN: begin
          if (sense_s || obs_s) begin
            hold_cnt <= '0;
          end else if (tick) begin
            if (hold_cnt == HOLD_LAST) begin
              state      <= CLOSING;
              motor      <= M_CLOSE;
              travel_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end

        CLOSING: begin
          if (obs_s && (retry_cnt == RETRY_LAST)) begin
            state     <= FAULT;
            motor     <= M_STOP;
            alarm     <= 1'b1;
            rev_pulse <= 1'b1;
          end else if (obs_s) begin
            state      <= OPENING;
            motor      <= M_OPEN;
            retry_cnt  <= retry_cnt + 1'b1;
            rev_pulse  <= 1'b1;
            travel_cnt <= '0;
          end else if (sense_s) begin
            state      <= OPENING;
            motor      <= M_OPEN;
            travel_cnt <= '0;
`ifdef LIMIT_SW_EN
          end else if (lim_closed_s) begin
            state <= CLOSED;
            motor <= M_STOP;
          end else if (tick) begin
            if (travel_last) begin
              state <= FAULT;
              motor <= M_STOP;
              alarm <= 1'b1;
            end else begin
              travel_cnt <= travel_cnt + 1'b1;
            end
          end
`else
          end else if (tick) begin
            if (travel_last) begin
              state <= CLOSED;
              motor <= M_STOP;
            end else begin
              travel_cnt <= travel_cnt + 1'b1;
            end
          end
`endif
        end

        FAULT: begin
          if (ack && !obs_s) begin
            state      <= OPENING;
            motor      <= M_OPEN;
            alarm      <= 1'b0;
            retry_cnt  <= '0;
            travel_cnt <= '0;
          end
        end

        default: begin
          state      <= CLOSED;
          motor      <= M_STOP;
          alarm      <= 1'b0;
          travel_cnt <= '0;
          hold_cnt   <= '0;
          retry_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_door_fsm_timed.sv
// Self-checking bench for door_fsm_timed: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the door rules.
module tb_door_fsm_timed;

  localparam int TD = 4;
  localparam int TT = 3;
  localparam int HT = 5;
  localparam int MR = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sense = 1'b0;
  logic       obs = 1'b0;
  logic       ack = 1'b0;
  logic [1:0] motor;
  logic       alarm;
  logic       rev_pulse;
  logic [2:0] state_o;
  logic       tick_led;
`ifdef LIMIT_SW_EN
  logic       lim_open = 1'b0;
  logic       lim_closed = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  door_fsm_timed #(
    .TICK_DIV(TD),
    .TRAVEL_TICKS(TT),
    .HOLD_TICKS(HT),
    .MAX_RETRIES(MR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sense(sense),
    .obs(obs),
    .ack(ack),
`ifdef LIMIT_SW_EN
    .lim_open(lim_open),
    .lim_closed(lim_closed),
`endif
    .motor(motor),
    .alarm(alarm),
    .rev_pulse(rev_pulse),
    .state_o(state_o),
    .tick_led(tick_led)
  );

  always #5 clk = ~clk;

  // Model: phase number, ticks elapsed in the phase, reversals used, clocks since reset.
  int m_state, m_trav, m_hold, m_retry, m_pc, m_ticks;
  bit m_rev;
  bit sense_hist[$];
  bit obs_hist[$];

  task automatic model_step();
    bit t, ss, os;
    if (rst) begin
      m_state = 0; m_trav = 0; m_hold = 0; m_retry = 0;
      m_pc = 0; m_ticks = 0; m_rev = 0;
      sense_hist = {1'b0, 1'b0};
      obs_hist = {1'b0, 1'b0};
    end else begin
      t = ((m_pc % TD) == TD - 1);
      ss = sense_hist[1];
      os = obs_hist[1];
      m_rev = 0;
      case (m_state)
        0: if (ss) begin m_state = 1; m_trav = 0; m_retry = 0; end
        1: if (t) begin
             if (m_trav == TT - 1) begin m_state = 2; m_hold = 0; end
             else m_trav++;
           end
        2: if (ss || os) m_hold = 0;
           else if (t) begin
             if (m_hold == HT - 1) begin m_state = 3; m_trav = 0; end
             else m_hold++;
           end
        3: if (os && m_retry == MR - 1) begin m_state = 4; m_rev = 1; end
           else if (os) begin m_state = 1; m_retry++; m_rev = 1; m_trav = 0; end
           else if (ss) begin m_state = 1; m_trav = 0; end
           else if (t) begin
             if (m_trav == TT - 1) m_state = 0;
             else m_trav++;
           end
        4: if (ack && !os) begin m_state = 1; m_retry = 0; m_trav = 0; end
        default: m_state = 0;
      endcase
      sense_hist.push_front(sense); void'(sense_hist.pop_back());
      obs_hist.push_front(obs);     void'(obs_hist.pop_back());
      m_pc++;
      if (t) m_ticks++;
    end
  endtask

  function automatic logic [7:0] model_vec();
    logic [1:0] mm;
    mm = (m_state == 1) ? 2'b01 : (m_state == 3) ? 2'b10 : 2'b00;
    return {mm, 1'(m_state == 4), m_rev, 3'(m_state), 1'(m_ticks % 2)};
  endfunction

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; sense = 0; obs = 0; ack = 0;
    repeat (3) cycle();
    checks++;
    if ({motor, alarm, rev_pulse, state_o, tick_led} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", {motor, alarm, rev_pulse, state_o, tick_led}, 8'h00);
    end
    rst = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      checks++;
      if ({motor, alarm, rev_pulse, state_o, tick_led} !== model_vec()) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, {motor, alarm, rev_pulse, state_o, tick_led}, model_vec());
      end
    end
    checks++;
    if (tick_led !== 1'b1) begin
      failures++;
      $display("FAIL tick_led_after_3_ticks got=%b exp=1", tick_led);
    end
  endtask

  task automatic test_open_close();
    bit [3:0] seen = '0;
    bit done = 0;
    sense = 1;
    for (int i = 0; i < 3; i++) cycle();
    sense = 0;
    checks++;
    if (state_o !== 3'd1 || motor !== 2'b01) begin
      failures++;
      $display("FAIL opening_latency got state=%0d motor=%b exp state=1 motor=01", state_o, motor);
    end
    for (int i = 0; i < 100 && !done; i++) begin
      cycle();
      checks++;
      if ({motor, alarm, rev_pulse, state_o, tick_led} !== model_vec()) begin
        failures++;
        $display("FAIL open_close cyc=%0d got=%b exp=%b", i, {motor, alarm, rev_pulse, state_o, tick_led}, model_vec());
      end
      if (state_o < 4) seen[state_o[1:0]] = 1'b1;
      if (state_o == 3'd0 && seen[3]) done = 1;
    end
    checks++;
    if (!done || seen[3:1] !== 3'b111 || motor !== 2'b00) begin
      failures++;
      $display("FAIL full_cycle got done=%0d seen=%b motor=%b exp done=1 seen=111 motor=00", done, seen[3:1], motor);
    end
  endtask

  task automatic run_until_closing(input string name);
    bit found = 0;
    for (int i = 0; i < 120 && !found; i++) begin
      cycle();
      checks++;
      if ({motor, alarm, rev_pulse, state_o, tick_led} !== model_vec()) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%b exp=%b", name, i, {motor, alarm, rev_pulse, state_o, tick_led}, model_vec());
      end
      if (m_state == 3) found = 1;
    end
    checks++;
    if (!found || state_o !== 3'd3) begin
      failures++;
      $display("FAIL %s_reach_closing got state=%0d exp=3", name, state_o);
    end
  endtask

  task automatic test_obstacle();
    sense = 1;
    repeat (3) cycle();
    sense = 0;
    run_until_closing("obstacle1");
    obs = 1; cycle(); obs = 0; cycle(); cycle();
    checks++;
    if (state_o !== 3'd1 || rev_pulse !== 1'b1 || motor !== 2'b01) begin
      failures++;
      $display("FAIL first_reversal got state=%0d rev=%b motor=%b exp state=1 rev=1 motor=01", state_o, rev_pulse, motor);
    end
    cycle();
    checks++;
    if (rev_pulse !== 1'b0) begin
      failures++;
      $display("FAIL rev_pulse_width got=%b exp=0", rev_pulse);
    end
    run_until_closing("obstacle2");
    obs = 1; cycle(); obs = 0; cycle(); cycle();
    checks++;
    if (state_o !== 3'd4 || alarm !== 1'b1 || motor !== 2'b00 || rev_pulse !== 1'b1) begin
      failures++;
      $display("FAIL retry_fault got state=%0d alarm=%b motor=%b rev=%b exp state=4 alarm=1 motor=00 rev=1", state_o, alarm, motor, rev_pulse);
    end
  endtask

  task automatic test_fault_ack();
    obs = 1;
    repeat (3) cycle();
    ack = 1; cycle(); ack = 0;
    repeat (3) cycle();
    checks++;
    if (state_o !== 3'd4 || alarm !== 1'b1) begin
      failures++;
      $display("FAIL ack_with_obs got state=%0d alarm=%b exp state=4 alarm=1", state_o, alarm);
    end
    obs = 0;
    repeat (3) cycle();
    ack = 1; cycle(); ack = 0;
    checks++;
    if (state_o !== 3'd1 || alarm !== 1'b0 || motor !== 2'b01) begin
      failures++;
      $display("FAIL ack_release got state=%0d alarm=%b motor=%b exp state=1 alarm=0 motor=01", state_o, alarm, motor);
    end
    checks++;
    if ({motor, alarm, rev_pulse, state_o, tick_led} !== model_vec()) begin
      failures++;
      $display("FAIL ack_model got=%b exp=%b", {motor, alarm, rev_pulse, state_o, tick_led}, model_vec());
    end
  endtask

  task automatic test_obs_final_tick();
    bit found = 0;
    rst = 1; cycle(); rst = 0;
    sense = 1; repeat (3) cycle(); sense = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_state == 3 && m_trav == TT - 1 && (m_pc % TD) == 1) found = 1;
      else cycle();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL final_tick_setup got found=0 exp found=1");
    end
    obs = 1; cycle(); obs = 0; cycle(); cycle();
    checks++;
    if (state_o !== 3'd1 || rev_pulse !== 1'b1 || motor !== 2'b01) begin
      failures++;
      $display("FAIL obs_beats_travel got state=%0d rev=%b motor=%b exp state=1 rev=1 motor=01", state_o, rev_pulse, motor);
    end
  endtask

  task automatic test_reset_mid_opening();
    sense = 1; repeat (3) cycle(); sense = 0;
    repeat (6) cycle();
    checks++;
    if (state_o !== 3'd1) begin
      failures++;
      $display("FAIL mid_opening_setup got state=%0d exp=1", state_o);
    end
    rst = 1; cycle(); rst = 0;
    checks++;
    if ({motor, alarm, rev_pulse, state_o, tick_led} !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_opening got=%b exp=%b", {motor, alarm, rev_pulse, state_o, tick_led}, 8'h00);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 6) sense = ~sense;
      obs = ($urandom_range(0, 99) < 4);
      ack = ($urandom_range(0, 99) < 10);
      rst = ($urandom_range(0, 999) < 3);
      cycle();
      checks++;
      if ({motor, alarm, rev_pulse, state_o, tick_led} !== model_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%b exp=%b", i, {motor, alarm, rev_pulse, state_o, tick_led}, model_vec());
      end
    end
    rst = 0; sense = 0; obs = 0; ack = 0;
  endtask

  initial begin
    test_reset();
    test_open_close();
    test_obstacle();
    test_fault_ack();
    test_obs_final_tick();
    test_reset_mid_opening();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
